// File: rtl/serout_shift_module.sv
// serout_shift_module: SEROUT write register and 10-bit async frame shifter (define SEROUT_MSB_FIRST_EN for MSB-first data)
module serout_shift_module (
  input  logic       clk,
  input  logic       reset,
  input  logic       enp,
  input  logic       enn,
  input  logic [7:0] D,
  input  logic       AddrDw,
  input  logic       Load,
  input  logic       Shift,
  output logic       Empty,
  output logic       DshiftOut
);
  logic [7:0] wrreg_q, wrreg_d, data;
  logic [9:0] sr_q, sr_d;
  logic [3:0] cnt_q, cnt_d;
  logic       empty_q, empty_d, dout_q, dout_d;
  logic       do_load, do_shift;
`ifdef SEROUT_MSB_FIRST_EN
  // data bits reversed so the MSB leaves right after the start bit
  always_comb begin
    data = '0;
    for (int i = 0; i < 8; i++) data[i] = wrreg_q[7-i];
  end
`else
  assign data = wrreg_q;
`endif
  // next state: load beats shift; load reads the write register before this strobe's write
  always_comb begin
    do_load  = enp & Load;
    do_shift = enn & Shift & (cnt_q != 4'd0) & ~do_load;
    wrreg_d  = (enp & AddrDw) ? D : wrreg_q;
    sr_d     = do_load ? {1'b1, data, 1'b0} : do_shift ? {1'b1, sr_q[9:1]} : sr_q;
    cnt_d    = do_load ? 4'd10 : do_shift ? cnt_q - 4'd1 : cnt_q;
    empty_d  = do_load ? 1'b0 : (do_shift && cnt_q == 4'd1) ? 1'b1 : empty_q;
    dout_d   = do_shift ? sr_q[0] : dout_q;
  end
  // state registers; reset aborts any frame and returns the line to mark
  always_ff @(posedge clk) begin
    if (reset) begin
      wrreg_q <= 8'h00;
      sr_q    <= 10'h3FF;
      cnt_q   <= 4'd0;
      empty_q <= 1'b1;
      dout_q  <= 1'b1;
    end else begin
      wrreg_q <= wrreg_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      empty_q <= empty_d;
      dout_q  <= dout_d;
    end
  end
  assign Empty     = empty_q;
  assign DshiftOut = dout_q;
endmodule

// File: tb/tb_serout_shift_module.sv
// tb_serout_shift_module: directed plus random checks of serout_shift_module against a bit-queue model
module tb_serout_shift_module;
  logic       clk = 1'b0;
  logic       reset, enp, enn, AddrDw, Load, Shift;
  logic [7:0] D;
  logic       Empty, DshiftOut;
  int         passed = 0, total = 0;
  logic [7:0] m_wr = 8'h00;
  logic       m_dout = 1'b1;
  logic       bits_q[$];
  logic [9:0] seq_lsb = 10'b1110010010;
  logic [9:0] seq_msb = 10'b1100100110;
  logic [9:0] seq_55  = 10'b1010101010;

  serout_shift_module dut (
    .clk(clk), .reset(reset), .enp(enp), .enn(enn), .D(D),
    .AddrDw(AddrDw), .Load(Load), .Shift(Shift),
    .Empty(Empty), .DshiftOut(DshiftOut)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
  endtask

  task automatic cyc(input logic r, input logic ep, input logic en, input logic ad,
                     input logic ld, input logic sh, input logic [7:0] d);
    reset = r; enp = ep; enn = en; AddrDw = ad; Load = ld; Shift = sh; D = d;
    @(posedge clk);
    #1;
    if (r) begin
      bits_q.delete();
      m_wr = 8'h00;
      m_dout = 1'b1;
    end else begin
      if (ep && ld) begin
        bits_q.delete();
        bits_q.push_back(1'b0);
        for (int i = 0; i < 8; i++)
`ifdef SEROUT_MSB_FIRST_EN
          bits_q.push_back(m_wr[7-i]);
`else
          bits_q.push_back(m_wr[i]);
`endif
        bits_q.push_back(1'b1);
      end else if (en && sh && bits_q.size() > 0) m_dout = bits_q.pop_front();
      if (ep && ad) m_wr = d;
    end
    chk("dout", DshiftOut, m_dout);
    chk("empty", Empty, bits_q.size() == 0);
  endtask

  initial begin
    logic [9:0] seq;
`ifdef SEROUT_MSB_FIRST_EN
    seq = seq_msb;
`else
    seq = seq_lsb;
`endif
    cyc(1, 0, 0, 0, 0, 0, 8'h00);
    cyc(1, 0, 0, 0, 0, 0, 8'h00);
    chk("rst_empty", Empty, 1'b1);
    chk("rst_dout", DshiftOut, 1'b1);
    for (int i = 0; i < 10; i++) cyc(0, 0, 1, 0, 0, 1, 8'h00);
    chk("idle_shift_dout", DshiftOut, 1'b1);
    cyc(0, 1, 0, 1, 0, 0, 8'hC9);
    cyc(0, 1, 0, 0, 1, 0, 8'h00);
    chk("load_empty", Empty, 1'b0);
    chk("load_dout", DshiftOut, 1'b1);
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 1, 0, 0, 1, 8'h00);
      chk("c9_bit", DshiftOut, seq[i]);
      chk("c9_empty", Empty, i == 9);
    end
    cyc(0, 0, 1, 0, 0, 1, 8'h00);
    chk("after_stop", DshiftOut, 1'b1);
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 1, 1, 1, 8'hA5);
    chk("nostrobe_empty", Empty, 1'b1);
    cyc(0, 1, 0, 0, 1, 0, 8'h00);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 0, 1, 8'h00);
    cyc(0, 1, 0, 1, 0, 0, 8'h55);
    cyc(0, 1, 0, 0, 1, 0, 8'h00);
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 1, 0, 0, 1, 8'h00);
`ifndef SEROUT_MSB_FIRST_EN
      chk("restart_55", DshiftOut, seq_55[i]);
`endif
    end
    cyc(0, 1, 0, 0, 1, 0, 8'h00);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0, 1, 8'h00);
    cyc(1, 0, 1, 0, 0, 1, 8'h00);
    chk("midrst_empty", Empty, 1'b1);
    chk("midrst_dout", DshiftOut, 1'b1);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0, 0, 1, 8'h00);
    cyc(0, 1, 1, 1, 1, 1, 8'h3C);
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 0,
          $urandom_range(0, 1) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
          8'($urandom));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/serout_shift_module.md
Name: serout_shift_module

Overview:
- Serial-output (SEROUT) transmit path of the POKEY core: an 8-bit write-holding register, plus a 10-bit frame shift register.
- The frame shifter sends an asynchronous-serial frame: start bit, 8 data bits LSB first, stop bit.
- Runs on the fast system clock `clk`. Work is gated by the slow-clock (1.79 MHz) edge strobes: `enp` qualifies register writes and loads; `enn` qualifies shifting.
- Sits between the CPU register-write decode and the serial output pin / IRQ logic.

Parameters:
- None. All widths are fixed: 8-bit data, 10-bit frame, 4-bit bit counter.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- enp  input  1  one-`clk`-wide strobe at each slow-clock rising edge.
- enn  input  1  one-`clk`-wide strobe at each slow-clock falling edge.
- D  input  8  CPU data bus.
- AddrDw  input  1  SEROUT register write select; sampled only when `enp` = 1.
- Load  input  1  transfer request, write register to shift register; sampled only when `enp` = 1.
- Shift  input  1  shift request, one bit per strobe; sampled only when `enn` = 1.
- Empty  output  1  1 = shifter idle / frame fully transmitted.
- DshiftOut  output  1  registered serial output; idle level is 1 (mark).

Behaviour:
- Reset, sampled on a `clk` rising edge with `reset` = 1:
  - write register = 0x00
  - shift register = 10'h3FF
  - bit counter = 0
  - `Empty` = 1
  - `DshiftOut` = 1
  - `reset` overrides every other input.
  - Reset mid-frame aborts the frame immediately; the output returns to 1 on the next edge.
- Write:
  - On a clock edge where `enp` & `AddrDw`, the write register takes `D`.
  - The write register holds its value otherwise.
- Load:
  - On a clock edge where `enp` & `Load`:
    - shift register takes {1'b1 stop, wrreg[7:0], 1'b0 start}, so bit 0 is shifted out first;
    - bit counter = 10;
    - `Empty` = 0.
  - `DshiftOut` is unchanged by Load.
  - Load while a frame is in progress restarts the frame with the new data.
- Write and Load on the same strobe: Load uses the write-register value from before this strobe. The new `D` is stored for the next Load.
- Shift:
  - On a clock edge where `enn` & `Shift` & counter ≠ 0:
    - `DshiftOut` takes sr[0];
    - shift register shifts right with 1 filled into bit 9;
    - counter decrements.
  - When the counter reaches 0 on that same edge, `Empty` = 1.
  - Shift with counter = 0 has no effect; `DshiftOut` keeps its last value (the stop bit = 1).
- Latency:
  - Each output bit appears one `clk` after the qualifying `enn` strobe.
  - The start bit appears on the first Shift after Load.
  - `Empty` rises on the same edge that outputs the stop bit (the 10th Shift).
- `Shift` and `Load` held high across several strobes act once per strobe. Level-held inputs without a strobe do nothing.
- Simultaneous qualifying Load and Shift in one cycle: Load wins and the Shift is dropped.
- Strobes are one `clk` wide; the block does no edge detection of its own.

Optional Feature:
- Macro: `SEROUT_MSB_FIRST_EN`.
- When defined, the loaded frame is {1'b1, bit-reversed wrreg, 1'b0}, so the data goes out MSB first.
- Start bit, stop bit, counter and `Empty` behave identically either way.
- When not defined, data goes out LSB first (default, POKEY-compatible).

Test Plan:
1. Reset held 2 cycles → `Empty` = 1, `DshiftOut` = 1. Ten Shift strobes with no Load → outputs remain 1/1.
2. `D` = 0xC9, AddrDw strobe (enp), then Load strobe (enp) → `Empty` = 0 and `DshiftOut` still 1. Ten Shift strobes (enn) → `DshiftOut` sequence 0,1,0,0,1,0,0,1,1,1. `Empty` goes to 1 on the 10th strobe. An 11th strobe leaves `DshiftOut` = 1.
3. Same as 2 with `SEROUT_MSB_FIRST_EN` defined → sequence 0,1,1,0,0,1,0,0,1,1.
4. `AddrDw` and `Load` asserted without any `enp` strobe for many cycles → no change to the write register, `Empty` or `DshiftOut`. `Shift` asserted without `enn` → no shifting.
5. Load 0xC9, shift 4 bits, write 0x55 and Load → frame restarts. The next ten shifts give 0,1,0,1,0,1,0,1,0,1.
6. Assert reset after 3 shifts of a frame → next edge `Empty` = 1 and `DshiftOut` = 1. Subsequent Shift strobes have no effect.
